// File: rtl/vga_line_reader.sv
// vga_line_reader
//   Display-side reader for the horizontal scaler's output line buffer.
//   Runs the VGA raster counters on the pixel clock, steps the line-buffer
//   read address with h_data_ren, requests the next line from the scaler
//   with line_end, and registers the returned Y/Cb/Cr words to the pixel
//   outputs (black padding outside the image window, zero in blanking).
//
// Ports
//   clk, rst            pixel clock, synchronous active-high reset
//   enable              raster run enable (low: counters and outputs held at 0)
//   vga_target_width    image window width in pixels (clamped to H_ACTIVE)
//   vga_target_height   image window height in lines (clamped to V_ACTIVE)
//   h_data_ren          line-buffer read enable, aligned with the raster counters
//   line_end            LE_PULSE-cycle fill request for the next image line
//   frame_start         one-cycle pulse at h=0, v=0
//   Y_in, Cb_in, Cr_in  line-buffer read data, RD_LAT cycles after h_data_ren
//   vga_y/cb/cr         pixel outputs, RD_LAT+1 cycles after the raster position
//   hsync, vsync, de    timing outputs, aligned with the pixel outputs
module vga_line_reader #(
  parameter int H_ACTIVE   = 800,
  parameter int H_FP       = 40,
  parameter int H_SYNC     = 128,
  parameter int H_BP       = 88,
  parameter int V_ACTIVE   = 600,
  parameter int V_FP       = 1,
  parameter int V_SYNC     = 4,
  parameter int V_BP       = 23,
  parameter int IMGO_WIDTH = 11,
  parameter int RD_LAT     = 1,
  parameter int LE_PULSE   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [IMGO_WIDTH-1:0] vga_target_width,
  input  logic [IMGO_WIDTH-1:0] vga_target_height,
  output logic                  h_data_ren,
  output logic                  line_end,
  output logic                  frame_start,
  input  logic [7:0]            Y_in,
  input  logic [7:0]            Cb_in,
  input  logic [7:0]            Cr_in,
  output logic [7:0]            vga_y,
  output logic [7:0]            vga_cb,
  output logic [7:0]            vga_cr,
  output logic                  hsync,
  output logic                  vsync,
  output logic                  de
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int LW      = $clog2(LE_PULSE + 1);

  localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_C = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG  = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END  = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_C = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG  = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END  = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [31:0]   H_ACT32 = 32'(H_ACTIVE);
  localparam logic [31:0]   V_ACT32 = 32'(V_ACTIVE);
  localparam logic [LW-1:0] LE_LOAD = LW'(LE_PULSE - 1);

  // Elaboration-time parameter checks.
  if (LE_PULSE < 1 || LE_PULSE > H_TOTAL - H_ACTIVE) begin : g_le_pulse_check
    $error("vga_line_reader: LE_PULSE must lie in 1..H_TOTAL-H_ACTIVE");
  end
  if (RD_LAT < 1 || RD_LAT > 3) begin : g_rd_lat_check
    $error("vga_line_reader: RD_LAT must lie in 1..3");
  end

  logic            run;
  logic [HW-1:0]   h_cnt, h_nxt, w_sh, w_in, w_nxt;
  logic [VW-1:0]   v_cnt, v_nxt, hh_sh, hh_in, hh_nxt, nl_nxt;
  logic [LW-1:0]   le_cnt, le_cnt_nxt;
  logic            frm_nxt, ren_nxt, le_start;
  logic            act_c, hs_c, vs_c;
  logic [31:0]     tw32, th32;
  logic [RD_LAT-1:0] act_d, hs_d, vs_d, win_d;

  // Next raster position. The registered h_data_ren/line_end/frame_start are
  // computed from it so that they coincide with h_cnt/v_cnt in the same cycle.
  // While not yet running, the next position is the frame origin.
  always_comb begin
    h_nxt = '0;
    v_nxt = '0;
    if (run) begin
      if (h_cnt == H_LAST) begin
        h_nxt = '0;
        v_nxt = (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
      end else begin
        h_nxt = h_cnt + 1'b1;
        v_nxt = v_cnt;
      end
    end
  end

  always_comb begin
    tw32       = 32'(vga_target_width);
    th32       = 32'(vga_target_height);
    w_in       = (tw32 > H_ACT32) ? H_ACT_C : HW'(tw32);
    hh_in      = (th32 > V_ACT32) ? V_ACT_C : VW'(th32);
    frm_nxt    = (h_nxt == '0) && (v_nxt == '0);
    // Window config is only taken on entry to the frame origin.
    w_nxt      = frm_nxt ? w_in : w_sh;
    hh_nxt     = frm_nxt ? hh_in : hh_sh;
    ren_nxt    = (h_nxt < w_nxt) && (v_nxt < hh_nxt);
    // Line following the next position; the last line requests line 0.
    nl_nxt     = (v_nxt == V_LAST) ? '0 : v_nxt + 1'b1;
    le_start   = (h_nxt == H_ACT_C) && (nl_nxt < hh_nxt) && (w_nxt != '0);
    le_cnt_nxt = '0;
    if (le_start) begin
      le_cnt_nxt = LE_LOAD;
    end else if (le_cnt != '0) begin
      le_cnt_nxt = le_cnt - 1'b1;
    end
    act_c      = run && (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
    hs_c       = run && (h_cnt >= HS_BEG) && (h_cnt <= HS_END);
    vs_c       = run && (v_cnt >= VS_BEG) && (v_cnt <= VS_END);
  end

  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      run         <= 1'b0;
      h_cnt       <= '0;
      v_cnt       <= '0;
      w_sh        <= '0;
      hh_sh       <= '0;
      le_cnt      <= '0;
      frame_start <= 1'b0;
      h_data_ren  <= 1'b0;
      line_end    <= 1'b0;
      act_d       <= '0;
      hs_d        <= '0;
      vs_d        <= '0;
      win_d       <= '0;
      de          <= 1'b0;
      hsync       <= 1'b0;
      vsync       <= 1'b0;
      vga_y       <= '0;
      vga_cb      <= '0;
      vga_cr      <= '0;
    end else begin
      run         <= 1'b1;
      h_cnt       <= h_nxt;
      v_cnt       <= v_nxt;
      w_sh        <= w_nxt;
      hh_sh       <= hh_nxt;
      le_cnt      <= le_cnt_nxt;
      frame_start <= frm_nxt;
      h_data_ren  <= ren_nxt;
      line_end    <= le_start || (le_cnt != '0);

      // Timing flags ride alongside the read latency; the window flag is the
      // read enable itself, so the data select lines up with Y/Cb/Cr_in.
      act_d[0] <= act_c;
      hs_d[0]  <= hs_c;
      vs_d[0]  <= vs_c;
      win_d[0] <= h_data_ren;
      for (int i = 1; i < RD_LAT; i++) begin
        act_d[i] <= act_d[i-1];
        hs_d[i]  <= hs_d[i-1];
        vs_d[i]  <= vs_d[i-1];
        win_d[i] <= win_d[i-1];
      end

      de    <= act_d[RD_LAT-1];
      hsync <= hs_d[RD_LAT-1];
      vsync <= vs_d[RD_LAT-1];
      if (act_d[RD_LAT-1]) begin
        if (win_d[RD_LAT-1]) begin
          vga_y  <= Y_in;
          vga_cb <= Cb_in;
          vga_cr <= Cr_in;
        end else begin
          vga_y  <= 8'd16;
          vga_cb <= 8'd128;
          vga_cr <= 8'd128;
        end
      end else begin
        vga_y  <= '0;
        vga_cb <= '0;
        vga_cr <= '0;
      end
    end
  end

endmodule

// File: tb/tb_vga_line_reader.sv
// Testbench for vga_line_reader on a 24x7 raster (16x4 active), RD_LAT=1,
// LE_PULSE=4. Bench time t counts sample points (negedges) from the first
// enabled cycle; raster position at t is h=t%24, v=(t/24)%7, and the
// delayed outputs (de/syncs/data) reflect the position two cycles earlier.
module tb_vga_line_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [10:0] vga_target_width = '0;
  logic [10:0] vga_target_height = '0;
  logic        h_data_ren, line_end, frame_start;
  logic [7:0]  Y_in = '0, Cb_in = '0, Cr_in = '0;
  logic [7:0]  vga_y, vga_cb, vga_cr;
  logic        hsync, vsync, de;

  vga_line_reader #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .IMGO_WIDTH(11), .RD_LAT(1), .LE_PULSE(4)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .vga_target_width(vga_target_width), .vga_target_height(vga_target_height),
    .h_data_ren(h_data_ren), .line_end(line_end), .frame_start(frame_start),
    .Y_in(Y_in), .Cb_in(Cb_in), .Cr_in(Cr_in),
    .vga_y(vga_y), .vga_cb(vga_cb), .vga_cr(vga_cr),
    .hsync(hsync), .vsync(vsync), .de(de)
  );

  always #5 clk = ~clk;

  // Line-buffer model: returns the read address one cycle after h_data_ren.
  logic [7:0] addr = '0;
  always @(posedge clk) begin
    if (h_data_ren) begin
      Y_in  <= addr;
      Cb_in <= addr + 8'd100;
      Cr_in <= addr + 8'd200;
      addr  <= addr + 8'd1;
    end else begin
      addr <= '0;
    end
  end

  int checks = 0;
  int errors = 0;
  int t = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    t++;
  endtask

  task automatic adv_to(input int target);
    while (t < target) step();
  endtask

  // Reset, then release with enable high; returns at the t=0 sample point.
  task automatic go(input int w, input int hh);
    rst = 1'b1;
    enable = 1'b1;
    vga_target_width = 11'(w);
    vga_target_height = 11'(hh);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    t = 0;
  endtask

  function automatic logic [31:0] all_out();
    return {7'd0, h_data_ren, line_end, frame_start, hsync, vsync, de, vga_y, vga_cb, vga_cr} != 0;
  endfunction

  typedef struct {
    int t; int ren; int le; int fs; int hs; int vs; int de; int y; int cb;
  } vec_t;
  vec_t vecs[20];

  int de_cnt, hs_first, hs_cnt, ren_cnt, le_cnt, bad, n;
  int de_line[7];
  int le_starts[$];
  logic le_prev;

  initial begin
    //          t    ren le fs hs vs de  y   cb
    vecs[0]  = '{0,   1, 0, 1, 0, 0, 0,  0,   0};
    vecs[1]  = '{1,   1, 0, 0, 0, 0, 0,  0,   0};
    vecs[2]  = '{2,   1, 0, 0, 0, 0, 1,  0, 100};
    vecs[3]  = '{7,   1, 0, 0, 0, 0, 1,  5, 105};
    vecs[4]  = '{17,  0, 1, 0, 0, 0, 1, 15, 115};
    vecs[5]  = '{18,  0, 1, 0, 0, 0, 0,  0,   0};
    vecs[6]  = '{20,  0, 0, 0, 1, 0, 0,  0,   0};
    vecs[7]  = '{22,  0, 0, 0, 1, 0, 0,  0,   0};
    vecs[8]  = '{23,  0, 0, 0, 0, 0, 0,  0,   0};
    vecs[9]  = '{24,  1, 0, 0, 0, 0, 0,  0,   0};
    vecs[10] = '{89,  0, 0, 0, 0, 0, 1, 15, 115};
    vecs[11] = '{112, 0, 0, 0, 0, 0, 0,  0,   0};
    vecs[12] = '{121, 0, 0, 0, 0, 0, 0,  0,   0};
    vecs[13] = '{122, 0, 0, 0, 0, 1, 0,  0,   0};
    vecs[14] = '{145, 0, 0, 0, 0, 1, 0,  0,   0};
    vecs[15] = '{146, 0, 0, 0, 0, 0, 0,  0,   0};
    vecs[16] = '{160, 0, 1, 0, 0, 0, 0,  0,   0};
    vecs[17] = '{168, 1, 0, 1, 0, 0, 0,  0,   0};
    vecs[18] = '{170, 1, 0, 0, 0, 0, 1,  0, 100};
    vecs[19] = '{171, 1, 0, 0, 0, 0, 1,  1, 101};

    // Reset state.
    rst = 1'b1;
    enable = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset.outputs", all_out(), 0);

    // Full window table.
    go(16, 4);
    for (int i = 0; i < 20; i++) begin
      adv_to(vecs[i].t);
      chk($sformatf("vec%0d.ren", i), h_data_ren, vecs[i].ren);
      chk($sformatf("vec%0d.le", i), line_end, vecs[i].le);
      chk($sformatf("vec%0d.fs", i), frame_start, vecs[i].fs);
      chk($sformatf("vec%0d.hs", i), hsync, vecs[i].hs);
      chk($sformatf("vec%0d.vs", i), vsync, vecs[i].vs);
      chk($sformatf("vec%0d.de", i), de, vecs[i].de);
      chk($sformatf("vec%0d.y", i), vga_y, vecs[i].y);
      chk($sformatf("vec%0d.cb", i), vga_cb, vecs[i].cb);
    end

    // hsync extent, de per line, frame_start period.
    go(16, 4);
    de_cnt = 0; hs_first = -1; hs_cnt = 0;
    for (int l = 0; l < 7; l++) de_line[l] = 0;
    for (int k = 0; k < 168; k++) begin
      if (k > 0) step();
      if (de) begin
        de_cnt++;
        if (k >= 2) de_line[(k - 2) / 24]++;
      end
      if (hsync && k < 24) begin
        if (hs_first < 0) hs_first = k;
        hs_cnt++;
      end
    end
    chk("hsync.first_h", hs_first - 2, 18);
    chk("hsync.len", hs_cnt, 3);
    chk("de.frame_total", de_cnt, 64);
    for (int l = 0; l < 7; l++)
      chk($sformatf("de.line%0d", l), de_line[l], (l < 4) ? 16 : 0);
    n = 0;
    do begin step(); n++; end while (!frame_start && n < 400);
    chk("frame_start.period", t, 168);

    // W=10, Hh=2 window.
    go(10, 2);
    ren_cnt = 0; le_cnt = 0; bad = 0; le_prev = 1'b0;
    le_starts.delete();
    for (int k = 0; k < 168; k++) begin
      if (k > 0) step();
      if (h_data_ren) ren_cnt++;
      if (h_data_ren !== (((k % 24) < 10) && ((k / 24) < 2))) bad++;
      if (line_end) le_cnt++;
      if (line_end && !le_prev) le_starts.push_back(k);
      le_prev = line_end;
      if (k == 11) begin
        chk("w10.pix9.y", vga_y, 9);
        chk("w10.pix9.cr", vga_cr, 209);
      end
      if (k == 12 || k == 17) begin
        chk($sformatf("w10.pad%0d.y", k - 2), vga_y, 16);
        chk($sformatf("w10.pad%0d.cb", k - 2), vga_cb, 128);
        chk($sformatf("w10.pad%0d.cr", k - 2), vga_cr, 128);
        chk($sformatf("w10.pad%0d.de", k - 2), de, 1);
      end
      if (k == 55 || k == 74) begin
        chk($sformatf("w10.black_t%0d.y", k), vga_y, 16);
        chk($sformatf("w10.black_t%0d.cb", k), vga_cb, 128);
        chk($sformatf("w10.black_t%0d.de", k), de, 1);
      end
    end
    chk("w10.ren_count", ren_cnt, 20);
    chk("w10.ren_pattern_bad", bad, 0);
    chk("w10.le_cycles", le_cnt, 8);
    chk("w10.le_pulses", le_starts.size(), 2);
    if (le_starts.size() == 2) begin
      chk("w10.le_start0", le_starts[0], 16);
      chk("w10.le_start1", le_starts[1], 160);
    end

    // Mid-frame width change.
    go(10, 4);
    adv_to(30);
    vga_target_width = 11'd12;
    ren_cnt = 0;
    adv_to(48);
    for (int k = 48; k < 72; k++) begin
      if (h_data_ren) ren_cnt++;
      step();
    end
    chk("wchg.cur_frame_ren", ren_cnt, 10);
    adv_to(168);
    ren_cnt = 0;
    for (int k = 168; k < 192; k++) begin
      if (h_data_ren) ren_cnt++;
      step();
    end
    chk("wchg.next_frame_ren", ren_cnt, 12);

    // Reset mid-line at h=5, v=1.
    go(16, 4);
    adv_to(29);
    chk("rst.pre_de", de, 1);
    rst = 1'b1;
    step();
    chk("rst.outputs_zero", all_out(), 0);
    rst = 1'b0;
    step();
    t = 0;
    chk("rst.restart_fs", frame_start, 1);
    chk("rst.restart_ren", h_data_ren, 1);
    adv_to(3);
    chk("rst.restart_y", vga_y, 1);

    // Reset truncates a line_end pulse.
    go(16, 4);
    adv_to(17);
    chk("rst_le.pre", line_end, 1);
    rst = 1'b1;
    step();
    chk("rst_le.truncated", line_end, 0);
    rst = 1'b0;

    // enable low for 50 cycles, then a W=0 frame.
    go(16, 4);
    adv_to(40);
    enable = 1'b0;
    vga_target_width = 11'd0;
    bad = 0;
    for (int k = 0; k < 50; k++) begin
      step();
      if (all_out() != 0) bad++;
    end
    chk("en_low.outputs_zero_cycles", bad, 0);
    enable = 1'b1;
    step();
    t = 0;
    chk("en_rise.fs", frame_start, 1);
    ren_cnt = 0; le_cnt = 0;
    for (int k = 0; k < 168; k++) begin
      if (k > 0) step();
      if (h_data_ren) ren_cnt++;
      if (line_end) le_cnt++;
      if (k == 4) begin
        chk("w0.pad.y", vga_y, 16);
        chk("w0.pad.de", de, 1);
      end
    end
    chk("w0.ren_count", ren_cnt, 0);
    chk("w0.le_count", le_cnt, 0);

    // Width beyond H_ACTIVE clamps to a full line with no padding.
    go(20, 4);
    ren_cnt = 0;
    for (int k = 0; k < 24; k++) begin
      if (k > 0) step();
      if (h_data_ren) ren_cnt++;
      if (k == 17) chk("clamp.pix15.y", vga_y, 15);
    end
    chk("clamp.ren_count", ren_cnt, 16);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
